jump_sequencer: RTL and testbench

JUMP_SEQUENCER -- requirements
Module: jump_sequencer

---
 rtl/jump_sequencer.sv | 222 ++++++++++++++++++++++
 tb/tb_jump_sequencer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/jump_sequencer.sv
// Character jump controller: walk, charge-up and ballistic jump sequencing,
// advanced once per video frame, emitting signed per-frame X/Y motion steps.
module jump_sequencer #(
    parameter int CHARGE_DIV = 3,
    parameter int CHARGE_MAX = 15,
    parameter int JUMP_X     = 2,
    parameter int FALL_MAX   = 4
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic       frame_tick,
    input  logic [7:0] keycode0,
    input  logic [7:0] keycode1,
    input  logic       left_collide,
    input  logic       right_collide,
    input  logic       top_collide,
    input  logic       bottom_collide,
    output logic [9:0] Char_X_Motion,
    output logic [9:0] Char_Y_Motion,
    output logic [3:0] charge_level,
    output logic [3:0] HEXstate,
    output logic       airborne
);

    // state  | meaning
    // IDLE   | grounded, standing still
    // WALK   | grounded, stepping one pixel per frame
    // CHARGE | SPACE held, building jump charge
    // RISE   | airborne, upward speed decaying
    // FALL   | airborne, accelerating down to terminal speed
    // LAND   | one-frame touchdown, clears jump context
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WALK   = 3'd1,
        ST_CHARGE = 3'd2,
        ST_RISE   = 3'd3,
        ST_FALL   = 3'd4,
        ST_LAND   = 3'd5
    } state_t;

    localparam logic [7:0] KEY_SPACE = 8'h2C;
    localparam logic [7:0] KEY_LEFT  = 8'h04;
    localparam logic [7:0] KEY_RIGHT = 8'h07;

    localparam int               DIV_W    = (CHARGE_DIV > 1) ? $clog2(CHARGE_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CHARGE_DIV - 1);
    localparam logic [3:0]       CHG_MAX  = 4'(CHARGE_MAX);
    localparam logic [9:0]       JX       = 10'(JUMP_X);
    localparam logic [9:0]       VY_FMAX  = 10'(FALL_MAX);

    // direction is a 2-bit signed value: -1, 0 or +1
    localparam logic [1:0] DIR_NONE = 2'b00;
    localparam logic [1:0] DIR_POS  = 2'b01;
    localparam logic [1:0] DIR_NEG  = 2'b11;

    state_t           state, state_nxt;
    logic [3:0]       charge, charge_nxt;
    logic [DIV_W-1:0] div_cnt, div_nxt;
    logic [9:0]       vy, vy_nxt;
    logic [1:0]       dir, dir_nxt;
    logic [9:0]       x_mot, x_nxt;
    logic [9:0]       y_mot, y_nxt;

    logic       space_held, left_raw, right_raw, left_held, right_held;
    logic [1:0] key_dir;
    logic [9:0] walk_x;
    logic       wall_hit;
    logic [9:0] air_x;
    logic [1:0] air_dir;
    logic       div_wrap;
    logic [3:0] charge_up;
    logic [3:0] charge_cand;
    logic [9:0] launch_vy;
    logic [9:0] vy_dec;
    logic [9:0] vy_inc;

    function automatic logic [9:0] dir_step(input logic [1:0] d);
        case (d)
            DIR_POS: dir_step = JX;
            DIR_NEG: dir_step = 10'd0 - JX;
            default: dir_step = 10'd0;
        endcase
    endfunction

    assign space_held = (keycode0 == KEY_SPACE) || (keycode1 == KEY_SPACE);
    assign left_raw   = (keycode0 == KEY_LEFT)  || (keycode1 == KEY_LEFT);
    assign right_raw  = (keycode0 == KEY_RIGHT) || (keycode1 == KEY_RIGHT);
    assign left_held  = left_raw  && !right_raw;
    assign right_held = right_raw && !left_raw;
    assign key_dir    = right_held ? DIR_POS : (left_held ? DIR_NEG : DIR_NONE);

    // grounded step is zeroed when a wall blocks the requested direction
    assign walk_x = right_held ? (right_collide ? 10'd0 : 10'd1)
                  : left_held  ? (left_collide  ? 10'd0 : 10'h3FF)
                  : 10'd0;

    assign wall_hit = (left_collide && (dir == DIR_NEG)) || (right_collide && (dir == DIR_POS));
    assign air_x    = wall_hit ? 10'd0 : dir_step(dir);
    assign air_dir  = wall_hit ? (2'b00 - dir) : dir;

    assign div_wrap    = (div_cnt >= DIV_LAST);
    assign charge_up   = (charge == CHG_MAX) ? charge : charge + 4'd1;
    assign charge_cand = div_wrap ? charge_up : charge;
    assign launch_vy   = {6'd0, charge_cand} + 10'd1;

    assign vy_dec = vy - 10'd1;
    assign vy_inc = (vy >= VY_FMAX) ? VY_FMAX : vy + 10'd1;

    always_comb begin
        state_nxt  = state;
        charge_nxt = charge;
        div_nxt    = div_cnt;
        vy_nxt     = vy;
        dir_nxt    = dir;
        x_nxt      = 10'd0;
        y_nxt      = 10'd0;

        case (state)
            ST_IDLE: begin
                if (!bottom_collide) begin
                    state_nxt = ST_FALL;
                    vy_nxt    = 10'd0;
                end else if (space_held) begin
                    state_nxt  = ST_CHARGE;
                    charge_nxt = 4'd0;
                    div_nxt    = '0;
                end else if (key_dir != DIR_NONE) begin
                    state_nxt = ST_WALK;
                    x_nxt     = walk_x;
                end
            end
            ST_WALK: begin
                if (!bottom_collide) begin
                    state_nxt = ST_FALL;
                    vy_nxt    = 10'd0;
                end else if (space_held) begin
                    state_nxt  = ST_CHARGE;
                    charge_nxt = 4'd0;
                    div_nxt    = '0;
                end else if (key_dir == DIR_NONE) begin
                    state_nxt = ST_IDLE;
                end else begin
                    x_nxt = walk_x;
                end
            end
            ST_CHARGE: begin
                div_nxt    = div_wrap ? '0 : div_cnt + DIV_W'(1);
                charge_nxt = charge_cand;
                // launch on release, or when a further increment would exceed saturation
                if (!space_held || (div_wrap && (charge == CHG_MAX))) begin
                    state_nxt = ST_RISE;
                    dir_nxt   = key_dir;
                    vy_nxt    = launch_vy;
                    y_nxt     = 10'd0 - launch_vy;
                    x_nxt     = dir_step(key_dir);
                end
            end
            ST_RISE: begin
                dir_nxt = air_dir;
                x_nxt   = air_x;
                if (top_collide || (vy <= 10'd1)) begin
                    state_nxt = ST_FALL;
                    vy_nxt    = 10'd0;
                end else begin
                    vy_nxt = vy_dec;
                    y_nxt  = 10'd0 - vy_dec;
                end
            end
            ST_FALL: begin
                if (bottom_collide) begin
                    state_nxt = ST_LAND;
                    vy_nxt    = 10'd0;
                end else begin
                    dir_nxt = air_dir;
                    x_nxt   = air_x;
                    vy_nxt  = vy_inc;
                    y_nxt   = vy_inc;
                end
            end
            ST_LAND: begin
                state_nxt  = ST_IDLE;
                dir_nxt    = DIR_NONE;
                charge_nxt = 4'd0;
                div_nxt    = '0;
            end
            default: begin
                state_nxt  = ST_IDLE;
                dir_nxt    = DIR_NONE;
                charge_nxt = 4'd0;
                div_nxt    = '0;
                vy_nxt     = 10'd0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state   <= ST_IDLE;
            charge  <= 4'd0;
            div_cnt <= '0;
            vy      <= 10'd0;
            dir     <= DIR_NONE;
            x_mot   <= 10'd0;
            y_mot   <= 10'd0;
        end else if (frame_tick) begin
            state   <= state_nxt;
            charge  <= charge_nxt;
            div_cnt <= div_nxt;
            vy      <= vy_nxt;
            dir     <= dir_nxt;
            x_mot   <= x_nxt;
            y_mot   <= y_nxt;
        end
    end

    assign Char_X_Motion = x_mot;
    assign Char_Y_Motion = y_mot;
    assign charge_level  = charge;
    assign HEXstate      = {1'b0, state};
    assign airborne      = (state == ST_RISE) || (state == ST_FALL);

endmodule

// File: tb/tb_jump_sequencer.sv
// Bench for jump_sequencer: directed scenarios plus randomized play, compared
// every cycle against a frame-level behavioural model of the character.
module tb_jump_sequencer;

    localparam int CHARGE_DIV = 3;
    localparam int CHARGE_MAX = 15;
    localparam int JUMP_X     = 2;
    localparam int FALL_MAX   = 4;

    localparam int M_IDLE = 0, M_WALK = 1, M_CHARGE = 2, M_RISE = 3, M_FALL = 4, M_LAND = 5;

    logic       CLK;
    logic       Reset;
    logic       frame_tick;
    logic [7:0] keycode0, keycode1;
    logic       left_collide, right_collide, top_collide, bottom_collide;
    logic [9:0] Char_X_Motion, Char_Y_Motion;
    logic [3:0] charge_level, HEXstate;
    logic       airborne;

    int checks = 0;
    int errors = 0;

    // model state
    int m_state, m_charge, m_ticks, m_vy, m_dir, m_x, m_y;

    jump_sequencer #(
        .CHARGE_DIV(CHARGE_DIV), .CHARGE_MAX(CHARGE_MAX),
        .JUMP_X(JUMP_X), .FALL_MAX(FALL_MAX)
    ) dut (
        .CLK(CLK), .Reset(Reset), .frame_tick(frame_tick),
        .keycode0(keycode0), .keycode1(keycode1),
        .left_collide(left_collide), .right_collide(right_collide),
        .top_collide(top_collide), .bottom_collide(bottom_collide),
        .Char_X_Motion(Char_X_Motion), .Char_Y_Motion(Char_Y_Motion),
        .charge_level(charge_level), .HEXstate(HEXstate), .airborne(airborne)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = M_IDLE; m_charge = 0; m_ticks = 0; m_vy = 0; m_dir = 0; m_x = 0; m_y = 0;
    endtask

    // one frame of the character's rules, in plain integer arithmetic
    task automatic model_step();
        bit sp, lf, rt, wall;
        int kdir, old_charge;
        sp = (keycode0 == 8'h2C) || (keycode1 == 8'h2C);
        lf = (keycode0 == 8'h04) || (keycode1 == 8'h04);
        rt = (keycode0 == 8'h07) || (keycode1 == 8'h07);
        kdir = (rt && !lf) ? 1 : ((lf && !rt) ? -1 : 0);
        wall = (left_collide && m_dir == -1) || (right_collide && m_dir == 1);
        m_x = 0;
        m_y = 0;
        case (m_state)
            M_IDLE, M_WALK: begin
                if (!bottom_collide) begin
                    m_state = M_FALL; m_vy = 0;
                end else if (sp) begin
                    m_state = M_CHARGE; m_charge = 0; m_ticks = 0;
                end else if (kdir == 0) begin
                    m_state = M_IDLE;
                end else begin
                    m_state = M_WALK;
                    if (kdir == 1 && !right_collide) m_x = 1;
                    if (kdir == -1 && !left_collide) m_x = -1;
                end
            end
            M_CHARGE: begin
                old_charge = m_charge;
                m_ticks++;
                m_charge = (m_ticks / CHARGE_DIV > CHARGE_MAX) ? CHARGE_MAX : m_ticks / CHARGE_DIV;
                if (!sp || ((m_ticks % CHARGE_DIV == 0) && old_charge == CHARGE_MAX)) begin
                    m_state = M_RISE;
                    m_dir = kdir;
                    m_vy = m_charge + 1;
                    m_y = -m_vy;
                    m_x = kdir * JUMP_X;
                end
            end
            M_RISE: begin
                m_x = wall ? 0 : m_dir * JUMP_X;
                if (wall) m_dir = -m_dir;
                if (top_collide || m_vy - 1 <= 0) begin
                    m_state = M_FALL; m_vy = 0;
                end else begin
                    m_vy = m_vy - 1;
                    m_y = -m_vy;
                end
            end
            M_FALL: begin
                if (bottom_collide) begin
                    m_state = M_LAND; m_vy = 0;
                end else begin
                    m_x = wall ? 0 : m_dir * JUMP_X;
                    if (wall) m_dir = -m_dir;
                    m_vy = (m_vy + 1 > FALL_MAX) ? FALL_MAX : m_vy + 1;
                    m_y = m_vy;
                end
            end
            default: begin
                m_state = M_IDLE; m_dir = 0; m_charge = 0;
            end
        endcase
    endtask

    always @(posedge CLK) begin
        if (Reset === 1'b1 && frame_tick === 1'b1) model_step();
        #1;
        chk("x_motion", Char_X_Motion, 10'(m_x));
        chk("y_motion", Char_Y_Motion, 10'(m_y));
        chk("charge_level", {6'd0, charge_level}, 10'(m_charge));
        chk("hexstate", {6'd0, HEXstate}, 10'(m_state));
        chk("airborne", {9'd0, airborne}, {9'd0, (m_state == M_RISE || m_state == M_FALL)});
    end

    // one frame: tick posedge with given inputs, then a non-tick posedge with junk inputs
    task automatic do_tick(input logic [7:0] k0, input logic [7:0] k1,
                           input logic l, input logic r, input logic t, input logic b);
        @(negedge CLK);
        keycode0 = k0; keycode1 = k1;
        left_collide = l; right_collide = r; top_collide = t; bottom_collide = b;
        frame_tick = 1'b1;
        @(negedge CLK);
        frame_tick = 1'b0;
        keycode0 = 8'($urandom); keycode1 = 8'($urandom);
        left_collide = 1'($urandom); right_collide = 1'($urandom);
        top_collide = 1'($urandom); bottom_collide = 1'($urandom);
    endtask

    function automatic logic [7:0] rand_key();
        int r;
        r = $urandom_range(0, 9);
        if (r < 3) return 8'h00;
        if (r < 5) return 8'h2C;
        if (r < 7) return 8'h04;
        if (r < 9) return 8'h07;
        return 8'($urandom);
    endfunction

    initial begin
        logic [7:0] k0, k1;
        logic       launched;
        logic       b;
        Reset = 1'b0; frame_tick = 1'b0; keycode0 = 8'h00; keycode1 = 8'h00;
        left_collide = 1'b0; right_collide = 1'b0; top_collide = 1'b0; bottom_collide = 1'b1;
        model_reset();
        repeat (3) @(negedge CLK);
        chk("rst_x", Char_X_Motion, 10'd0);
        chk("rst_y", Char_Y_Motion, 10'd0);
        chk("rst_hex", {6'd0, HEXstate}, 10'd0);
        chk("rst_charge", {6'd0, charge_level}, 10'd0);

        // released with stimulus pending: nothing may move until a tick
        keycode0 = 8'h2C; bottom_collide = 1'b0;
        Reset = 1'b1;
        repeat (2) @(negedge CLK);
        chk("no_move_without_tick", {6'd0, HEXstate}, 10'd0);
        keycode0 = 8'h00; bottom_collide = 1'b1;

        // walk right for three frames, then stop
        for (int i = 0; i < 3; i++) begin
            do_tick(8'h07, 8'h00, 0, 0, 0, 1);
            chk("walk_hex", {6'd0, HEXstate}, 10'd1);
            chk("walk_x", Char_X_Motion, 10'd1);
        end
        do_tick(8'h00, 8'h00, 0, 0, 0, 1);
        chk("walk_stop_hex", {6'd0, HEXstate}, 10'd0);
        chk("walk_stop_x", Char_X_Motion, 10'd0);

        // nine frames of charge, release with RIGHT
        repeat (9) do_tick(8'h2C, 8'h00, 0, 0, 0, 1);
        do_tick(8'h07, 8'h00, 0, 0, 0, 1);
        chk("launch_charge", {6'd0, charge_level}, 10'd3);
        chk("launch_y", Char_Y_Motion, 10'h3FC);
        chk("launch_x", Char_X_Motion, 10'd2);
        do_tick(8'h00, 8'h00, 0, 0, 0, 0); chk("rise_y1", Char_Y_Motion, 10'h3FD);
        do_tick(8'h00, 8'h00, 0, 0, 0, 0); chk("rise_y2", Char_Y_Motion, 10'h3FE);
        do_tick(8'h00, 8'h00, 0, 0, 0, 0); chk("rise_y3", Char_Y_Motion, 10'h3FF);
        do_tick(8'h00, 8'h00, 0, 0, 0, 0);
        chk("apex_y", Char_Y_Motion, 10'd0);
        chk("apex_hex", {6'd0, HEXstate}, 10'd4);
        for (int i = 1; i <= 5; i++) begin
            do_tick(8'h00, 8'h00, 0, 0, 0, 0);
            chk("fall_y", Char_Y_Motion, 10'((i > 4) ? 4 : i));
            chk("fall_x", Char_X_Motion, 10'd2);
        end
        do_tick(8'h00, 8'h00, 0, 0, 0, 1);
        chk("land_hex", {6'd0, HEXstate}, 10'd5);
        chk("land_x", Char_X_Motion, 10'd0);
        chk("land_y", Char_Y_Motion, 10'd0);
        do_tick(8'h00, 8'h00, 0, 0, 0, 1);
        chk("post_land_hex", {6'd0, HEXstate}, 10'd0);
        chk("post_land_charge", {6'd0, charge_level}, 10'd0);

        // right-wall bounce during rise
        repeat (4) do_tick(8'h2C, 8'h00, 0, 0, 0, 1);
        do_tick(8'h07, 8'h00, 0, 0, 0, 1);
        chk("bounce_launch_y", Char_Y_Motion, 10'h3FE);
        do_tick(8'h00, 8'h00, 0, 1, 0, 0);
        chk("bounce_x0", Char_X_Motion, 10'd0);
        chk("bounce_y", Char_Y_Motion, 10'h3FF);
        do_tick(8'h00, 8'h00, 0, 0, 0, 0);
        chk("bounce_x_neg", Char_X_Motion, 10'h3FE);
        repeat (2) do_tick(8'h00, 8'h00, 0, 0, 0, 0);
        repeat (2) do_tick(8'h00, 8'h00, 0, 0, 0, 1);

        // saturating charge auto-launch
        launched = 1'b0;
        for (int i = 0; i < 60; i++) begin
            do_tick(8'h2C, 8'h00, 0, 0, 0, 1);
            if (!launched && HEXstate == 4'd3) begin
                launched = 1'b1;
                chk("auto_launch_y", Char_Y_Motion, 10'h3F0);
                chk("auto_launch_charge", {6'd0, charge_level}, 10'd15);
                chk("auto_launch_frame", 10'(i), 10'd48);
            end
        end
        chk("auto_launch_seen", {9'd0, launched}, 10'd1);
        chk("still_rising", {9'd0, airborne}, 10'd1);

        // asynchronous reset mid-rise, between edges
        #2;
        Reset = 1'b0;
        model_reset();
        #1;
        chk("async_rst_x", Char_X_Motion, 10'd0);
        chk("async_rst_y", Char_Y_Motion, 10'd0);
        chk("async_rst_hex", {6'd0, HEXstate}, 10'd0);
        chk("async_rst_air", {9'd0, airborne}, 10'd0);
        @(negedge CLK);
        Reset = 1'b1;

        // randomized play with sticky keys and state-biased collisions
        k0 = 8'h00; k1 = 8'h00;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 9) < 3) k0 = rand_key();
            if ($urandom_range(0, 9) < 2) k1 = rand_key();
            if (m_state == M_RISE || m_state == M_FALL) b = ($urandom_range(0, 5) == 0);
            else b = ($urandom_range(0, 9) != 0);
            do_tick(k0, k1, ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                    ($urandom_range(0, 15) == 0), b);
            if ($urandom_range(0, 399) == 0) begin
                #2;
                Reset = 1'b0;
                model_reset();
                @(negedge CLK);
                Reset = 1'b1;
            end
        end

        repeat (2) @(negedge CLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
